// File: rtl/mm_pkg.sv
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared widths and state encoding for the Montgomery multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_pkg;

  localparam int OP_W   = 256;
  localparam int WORD_W = 32;
  localparam int NWORDS = OP_W / WORD_W;
  localparam int MM_LAT = 25;

  // acc between words is < 2N; within a word it carries the full A*b_i sum
  localparam int ACC_W  = OP_W + 2;
  localparam int SUM_W  = OP_W + WORD_W + 1;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam int WBIT_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_AB = 3'd1,
    S_MUL_Q  = 3'd2,
    S_MUL_NM = 3'd3,
    S_SUB    = 3'd4
  } mm_state_e;

endpackage

`default_nettype wire

// File: rtl/mult_256x32_neg32.sv
// ============================================================================
// Module   : mult_256x32_neg32
// Purpose  : Combinational 256x32 multiplier with negated low product word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_256x32_neg32
  import mm_pkg::*;
(
  input  logic [OP_W-1:0]        a_i,
  input  logic [WORD_W-1:0]      b_i,
  output logic [OP_W+WORD_W-1:0] p_o,
  output logic [WORD_W-1:0]      neg_o
);

  assign p_o   = {{WORD_W{1'b0}}, a_i} * {{OP_W{1'b0}}, b_i};
  assign neg_o = -p_o[WORD_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mont_mul_seq.sv
// ============================================================================
// Module   : mont_mul_seq
// Purpose  : Word-serial Montgomery multiplier, R = A*B*2^-256 mod N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_mul_seq
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [OP_W-1:0]   n,
  input  logic [WORD_W-1:0] n_inv,
  output logic              busy,
  output logic              done,
  output logic [OP_W-1:0]   r
);

  mm_state_e           state_q, state_d;
  logic [OP_W-1:0]     a_q, b_q, n_q;
  logic [WORD_W-1:0]   ninv_q;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [WORD_W-1:0]   m_q, m_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [OP_W-1:0]     r_q, r_d;

  logic                w_accept;
  logic [OP_W-1:0]     w_mul_a;
  logic [WORD_W-1:0]   w_mul_b;
  logic [OP_W+WORD_W-1:0] w_p;
  logic [WORD_W-1:0]   w_neg;
  logic [SUM_W-1:0]    w_sum_ab;
  logic [SUM_W:0]      w_sum_nm;
  logic [ACC_W:0]      w_diff;
  logic                w_unused;

  assign w_accept = (state_q == S_IDLE) && start;

  always_comb begin
    w_mul_a = a_q;
    w_mul_b = b_q[{idx_q, {WBIT_W{1'b0}}} +: WORD_W];
    case (state_q)
      S_MUL_Q: begin
        w_mul_a = {{(OP_W-WORD_W){1'b0}}, acc_q[WORD_W-1:0]};
        w_mul_b = ninv_q;
      end
      S_MUL_NM: begin
        w_mul_a = n_q;
        w_mul_b = m_q;
      end
      default: ;
    endcase
  end

  mult_256x32_neg32 u_mult (
    .a_i   (w_mul_a),
    .b_i   (w_mul_b),
    .p_o   (w_p),
    .neg_o (w_neg)
  );

  assign w_sum_ab = acc_q + {1'b0, w_p};
  assign w_sum_nm = {1'b0, acc_q} + {2'b0, w_p};
  assign w_diff   = {1'b0, acc_q[ACC_W-1:0]} - {{(ACC_W+1-OP_W){1'b0}}, n_q};
  // Low word of the N*m sum is zero by construction; top diff bits are below N
  assign w_unused = ^{w_sum_nm[WORD_W-1:0], w_diff[ACC_W-1:OP_W]};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MUL_AB;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_MUL_AB: begin
        acc_d   = w_sum_ab;
        state_d = S_MUL_Q;
      end
      S_MUL_Q: begin
        m_d     = w_neg;
        state_d = S_MUL_NM;
      end
      S_MUL_NM: begin
        acc_d   = {{(SUM_W-ACC_W){1'b0}}, w_sum_nm[SUM_W:WORD_W]};
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(NWORDS-1)) ? S_SUB : S_MUL_AB;
      end
      S_SUB: begin
        r_d     = w_diff[ACC_W] ? acc_q[OP_W-1:0] : w_diff[OP_W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      ninv_q <= '0;
    end else if (w_accept) begin
      a_q    <= a;
      b_q    <= b;
      n_q    <= n;
      ninv_q <= n_inv;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

endmodule

`default_nettype wire

// File: tb/tb_mont_mul_seq.sv
// ============================================================================
// Module   : tb_mont_mul_seq
// Purpose  : Self-checking bench for the word-serial Montgomery multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mont_mul_seq;
  import mm_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] a, b, n;
  logic [31:0]  n_inv;
  logic         busy, done;
  logic [255:0] r;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mont_mul_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .n     (n),
    .n_inv (n_inv),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Montgomery reduction leaves the low word of acc+N*m at zero every word
  always @(negedge clk) begin
    if (rst === 1'b0 && dut.state_q == S_MUL_NM) begin
      checks++;
      if (dut.w_sum_nm[31:0] !== 32'd0) begin
        errors++;
        $display("FAIL acc_low_zero: low word %0h, required 0 at t=%0t", dut.w_sum_nm[31:0], $time);
      end
    end
  end

  typedef struct {
    logic [255:0] va;
    logic [255:0] vb;
    logic [255:0] vn;
    logic [31:0]  vi;
    logic [255:0] vr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] calc_ninv(input logic [31:0] n0);
    logic [31:0] x;
    x = n0;
    for (int k = 0; k < 5; k++) x = x * (32'd2 - n0 * x);
    return x;
  endfunction

  task automatic gen_rand(output logic [255:0] ga, output logic [255:0] gb,
                          output logic [255:0] gn, output logic [31:0] gi);
    logic [255:0] t1, t2;
    for (int j = 0; j < 8; j++) begin
      gn[j*32 +: 32] = $urandom;
      t1[j*32 +: 32] = $urandom;
      t2[j*32 +: 32] = $urandom;
    end
    gn[0] = 1'b1;
    if (gn == 256'd1) gn[255] = 1'b1;
    ga = t1 % gn;
    gb = t2 % gn;
    gi = calc_ninv(gn[31:0]);
  endtask

  task automatic run_op(input logic [255:0] ta, input logic [255:0] tb_, input logic [255:0] tn,
                        input logic [31:0] ti, output logic [255:0] res,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    a = ta; b = tb_; n = tn; n_inv = ti; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    res = r;
  endtask

  logic [255:0] res, ones;
  int           lat, bcyc, ndone, last_done;
  bit           aborted;
  logic [255:0] qa, qb, qn;
  logic [31:0]  qi;
  logic [511:0] lhs, rhs;

  initial begin
    ones = {256{1'b1}};
    vecs[0] = '{256'd1, 256'd1, 256'd13, 32'hC4EC4EC5, 256'd9};
    vecs[1] = '{ones - 256'd1, ones - 256'd1, ones, 32'hFFFFFFFF, 256'd1};
    vecs[2] = '{256'd0, 256'd5, 256'd13, 32'hC4EC4EC5, 256'd0};
    vecs[3] = '{256'd12, 256'd12, 256'd13, 32'hC4EC4EC5, 256'd9};
    vecs[4] = '{256'd5, 256'd7, 256'd13, 32'hC4EC4EC5, 256'd3};
    vecs[5] = '{256'd2, 256'd3, ones, 32'hFFFFFFFF, 256'd6};
    vecs[6] = '{256'd1 << 255, 256'd2, ones, 32'hFFFFFFFF, 256'd1};
    vecs[7] = '{ones - 256'd1, 256'd1, ones, 32'hFFFFFFFF, ones - 256'd1};

    rst = 1'b0; start = 1'b0; a = '0; b = '0; n = '0; n_inv = '0;
    #1 rst = 1'b1;
    #3;
    check("reset_busy", {255'd0, busy}, 256'd0);
    check("reset_done", {255'd0, done}, 256'd0);
    check("reset_r", r, 256'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].va, vecs[v].vb, vecs[v].vn, vecs[v].vi, res, lat, bcyc);
      check($sformatf("vec%0d_r", v), res, vecs[v].vr);
      check($sformatf("vec%0d_latency", v), lat, 256'd25);
      check($sformatf("vec%0d_busy_cycles", v), bcyc, 256'd25);
      @(negedge clk);
      check($sformatf("vec%0d_done_clears", v), {255'd0, done}, 256'd0);
    end

    // start re-pulsed with different operands at cycles 5 and 24 must be ignored
    @(negedge clk);
    a = 256'd5; b = 256'd7; n = 256'd13; n_inv = 32'hC4EC4EC5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c - 1 == 4 || c - 1 == 23) begin
        start = 1'b1; a = 256'd2; b = 256'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        res = r;
      end
    end
    start = 1'b0;
    check("repulse_done_count", ndone, 256'd1);
    check("repulse_r", res, 256'd3);
    check("repulse_idle_after", {255'd0, busy}, 256'd0);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 256'd1; b = 256'd1; n = 256'd13; n_inv = 32'hC4EC4EC5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {255'd0, busy}, 256'd0);
    check("midrst_done", {255'd0, done}, 256'd0);
    check("midrst_r", r, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_stale_done", ndone, 256'd0);
    run_op(256'd12, 256'd12, 256'd13, 32'hC4EC4EC5, res, lat, bcyc);
    check("midrst_restart_r", res, 256'd9);
    check("midrst_restart_latency", lat, 256'd25);

    // back-to-back random operations with start held high
    @(negedge clk);
    gen_rand(qa, qb, qn, qi);
    a = qa; b = qb; n = qn; n_inv = qi; start = 1'b1;
    last_done = 0;
    aborted = 1'b0;
    for (int k = 0; k < 1000 && !aborted; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!done && w < 60) begin
        @(negedge clk);
        w++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: op %0d no done within 60 cycles, required done", k);
        aborted = 1'b1;
      end else begin
        lhs = {r, 256'd0} % {256'd0, qn};
        rhs = ({256'd0, qa} * {256'd0, qb}) % {256'd0, qn};
        checks++;
        if (!(r < qn) || lhs != rhs) begin
          errors++;
          $display("FAIL rand_r op %0d: r=%0h r*R%%N=%0h, required r<N and A*B%%N=%0h",
                   k, r, lhs[255:0], rhs[255:0]);
        end
        if (k > 0) check($sformatf("rand_interval_%0d", k), cyc - last_done, 256'd26);
        last_done = cyc;
        if (k == 999) begin
          start = 1'b0;
        end else begin
          gen_rand(qa, qb, qn, qi);
          a = qa; b = qb; n = qn; n_inv = qi;
        end
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
